// File: rtl/pe_col_serializer.sv
// Column serializer behind the PE array: buffers one array word and emits only the
// finished kernel-width columns, one column of ROWS sums per AXI-Stream beat.
module pe_col_serializer #(
    parameter int unsigned COLS        = 8,
    parameter int unsigned ROWS        = 4,
    parameter int unsigned Y_BITS      = 32,
    parameter int unsigned KW2_BITS    = 3,
    parameter int unsigned TUSER_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          s_last,
    input  logic [COLS*ROWS*Y_BITS-1:0]   s_data,
    input  logic [KW2_BITS-1:0]           s_kw2,
    input  logic [TUSER_WIDTH-1:0]        s_user,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_last,
    output logic [ROWS*Y_BITS-1:0]        m_data,
    output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] m_col,
    output logic [TUSER_WIDTH-1:0]        m_user
);

    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
    // One spare bit so col_idx + K never wraps before the final-beat compare.
    localparam int unsigned IW = CW + 1;
    localparam int unsigned KW = KW2_BITS + 1;
    localparam int unsigned SW = ((IW > KW) ? IW : KW) + 1;
    localparam int unsigned DW = COLS * ROWS * Y_BITS;
    localparam int unsigned BW = ROWS * Y_BITS;

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                 state_q;
    logic [DW-1:0]          buf_data_q;
    logic [KW-1:0]          k_q;
    logic [TUSER_WIDTH-1:0] user_q;
    logic                   last_q;
    logic [IW-1:0]          col_idx_q;

    logic [KW-1:0] s_k;
    logic [SW-1:0] next_col;
    logic          final_beat;
    logic          take;

    assign s_k        = {s_kw2, 1'b1};
    assign next_col   = SW'(col_idx_q) + SW'(k_q);
    assign final_beat = (next_col >= SW'(COLS));

    // Ready depends only on state, counter and m_ready, never on s_valid.
    assign s_ready = resetn &&
                     ((state_q == StIdle) || ((state_q == StSend) && final_beat && m_ready));
    assign take    = s_valid && s_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            buf_data_q <= '0;
            k_q        <= '0;
            user_q     <= '0;
            last_q     <= 1'b0;
            col_idx_q  <= '0;
        end else if (take) begin
            // Covers both the idle capture and the overlap path on a final beat.
            state_q    <= StSend;
            buf_data_q <= s_data;
            k_q        <= s_k;
            user_q     <= s_user;
            last_q     <= s_last;
            col_idx_q  <= IW'({s_kw2, 1'b0});
        end else if ((state_q == StSend) && m_ready) begin
            if (final_beat) begin
                state_q <= StIdle;
            end else begin
                col_idx_q <= next_col[IW-1:0];
            end
        end
    end

    always_comb begin
        m_data = '0;
        for (int c = 0; c < int'(COLS); c++) begin
            if (col_idx_q == IW'(c)) begin
                m_data = buf_data_q[c*BW +: BW];
            end
        end
    end

    assign m_valid = (state_q == StSend);
    assign m_col   = col_idx_q[CW-1:0];
    assign m_user  = user_q;
    assign m_last  = m_valid && last_q && final_beat;

    k_fits_array: assert property (@(posedge clk) disable iff (!resetn)
        (s_valid && s_ready) |-> (32'(s_k) <= COLS));

endmodule

// File: tb/tb_pe_col_serializer.sv
// Self-checking bench for pe_col_serializer: directed and random words against a
// queue-based model of the expected column beats.
module tb_pe_col_serializer;

    localparam int COLS        = 8;
    localparam int ROWS        = 4;
    localparam int Y_BITS      = 32;
    localparam int KW2_BITS    = 3;
    localparam int TUSER_WIDTH = 16;
    localparam int DW          = COLS * ROWS * Y_BITS;
    localparam int BW          = ROWS * Y_BITS;
    localparam int CW          = $clog2(COLS);

    logic                   clk = 1'b0;
    logic                   resetn;
    logic                   s_valid;
    logic                   s_ready;
    logic                   s_last;
    logic [DW-1:0]          s_data;
    logic [KW2_BITS-1:0]    s_kw2;
    logic [TUSER_WIDTH-1:0] s_user;
    logic                   m_valid;
    logic                   m_ready;
    logic                   m_last;
    logic [BW-1:0]          m_data;
    logic [CW-1:0]          m_col;
    logic [TUSER_WIDTH-1:0] m_user;

    pe_col_serializer #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .Y_BITS     (Y_BITS),
        .KW2_BITS   (KW2_BITS),
        .TUSER_WIDTH(TUSER_WIDTH)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_last (s_last),
        .s_data (s_data),
        .s_kw2  (s_kw2),
        .s_user (s_user),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_last (m_last),
        .m_data (m_data),
        .m_col  (m_col),
        .m_user (m_user)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]          data;
        logic [KW2_BITS-1:0]    kw2;
        logic [TUSER_WIDTH-1:0] user;
        logic                   last;
    } word_t;

    typedef struct {
        logic [BW-1:0]          data;
        int                     col;
        logic [TUSER_WIDTH-1:0] user;
        logic                   last;
    } beat_t;

    word_t words[$];
    beat_t exp_q[$];
    int    beat_cols[$];
    logic  beat_lasts[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    gcyc = 0;
    int    first_cyc;
    int    last_cyc;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Kept columns are K-1, 2K-1, ... below COLS; the last kept one is the final beat.
    task automatic expand(input word_t w);
        int k;
        beat_t b;
        k = 2 * int'(w.kw2) + 1;
        for (int c = k - 1; c < COLS; c += k) begin
            b.data = w.data[c*BW +: BW];
            b.col  = c;
            b.user = w.user;
            b.last = w.last && (c + k >= COLS);
            exp_q.push_back(b);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic add_word(input logic [DW-1:0] d, input int kw2, input logic [15:0] u,
                            input logic l);
        word_t w;
        w.data = d;
        w.kw2  = KW2_BITS'(kw2);
        w.user = u;
        w.last = l;
        words.push_back(w);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_m_col"}, m_col, 0);
        check({tag, "_m_user"}, m_user, 0);
        check({tag, "_s_ready"}, s_ready, 0);
    endtask

    task automatic clear_logs();
        beat_cols.delete();
        beat_lasts.delete();
        first_cyc = -1;
        last_cyc  = -1;
    endtask

    // Entered and left at posedge+1. Inputs driven there, outputs sampled at negedge.
    task automatic run(input int ready_pct, input int valid_pct, input int rst_after,
                       input int budget);
        int               cyc = 0;
        int               hs_beats = 0;
        logic             accepted = 1'b0;
        logic             prev_hold = 1'b0;
        logic [BW-1:0]    p_data;
        logic [CW-1:0]    p_col;
        logic [15:0]      p_user;
        logic             p_last;
        while ((words.size() != 0 || exp_q.size() != 0) && cyc < budget) begin
            if (accepted) begin
                s_valid  = 1'b0;
                accepted = 1'b0;
            end
            if (!s_valid && words.size() != 0 && $urandom_range(99) < valid_pct) begin
                s_valid = 1'b1;
                s_data  = words[0].data;
                s_kw2   = words[0].kw2;
                s_user  = words[0].user;
                s_last  = words[0].last;
            end
            m_ready = ($urandom_range(99) < ready_pct);
            @(negedge clk);
            cyc++;
            gcyc++;
            check("m_valid", m_valid, exp_q.size() != 0);
            check("s_ready", s_ready, (exp_q.size() == 0) || (exp_q.size() == 1 && m_ready));
            if (m_valid && exp_q.size() != 0) begin
                check("m_data", m_data, exp_q[0].data);
                check("m_col", m_col, exp_q[0].col);
                check("m_user", m_user, exp_q[0].user);
                check("m_last", m_last, exp_q[0].last);
            end
            if (prev_hold) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, p_data);
                check("hold_col", m_col, p_col);
                check("hold_user", m_user, p_user);
                check("hold_last", m_last, p_last);
            end
            prev_hold = m_valid && !m_ready;
            p_data = m_data;
            p_col  = m_col;
            p_user = m_user;
            p_last = m_last;
            if (m_valid && m_ready && exp_q.size() != 0) begin
                beat_cols.push_back(int'(m_col));
                beat_lasts.push_back(m_last);
                if (first_cyc < 0) first_cyc = gcyc;
                last_cyc = gcyc;
                void'(exp_q.pop_front());
                hs_beats++;
            end
            if (s_valid && s_ready && !accepted) begin
                expand(words.pop_front());
                accepted = 1'b1;
            end
            if (rst_after >= 0 && hs_beats == rst_after) begin
                @(posedge clk);
                #1;
                resetn   = 1'b0;
                s_valid  = 1'b0;
                accepted = 1'b0;
                m_ready  = 1'b1;
                repeat (2) begin
                    @(negedge clk);
                    check_reset_outputs("mid_reset");
                end
                @(posedge clk);
                #1;
                resetn = 1'b1;
                exp_q.delete();
                words.delete();
                prev_hold = 1'b0;
                rst_after = -1;
                continue;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        check("drained", exp_q.size() + words.size(), 0);
    endtask

    initial begin
        logic [DW-1:0] d;
        resetn  = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        s_kw2   = '0;
        s_user  = '0;
        m_ready = 1'b0;
        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // kw2=1, col c row r = 100c+r: columns 2 and 5 only, last on 5.
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                d[(c*ROWS+r)*Y_BITS +: Y_BITS] = Y_BITS'(100 * c + r);
        clear_logs();
        add_word(d, 1, 16'h1234, 1'b1);
        run(100, 100, -1, 100);
        check("t1_nbeats", beat_cols.size(), 2);
        if (beat_cols.size() == 2) begin
            check("t1_col0", beat_cols[0], 2);
            check("t1_col1", beat_cols[1], 5);
            check("t1_last0", beat_lasts[0], 0);
            check("t1_last1", beat_lasts[1], 1);
        end

        // kw2=0 back-to-back: 16 beats with no bubble.
        clear_logs();
        add_word(rand_data(), 0, 16'h0001, 1'b0);
        add_word(rand_data(), 0, 16'h0002, 1'b1);
        run(100, 100, -1, 100);
        check("t2_nbeats", beat_cols.size(), 16);
        check("t2_span", last_cyc - first_cyc + 1, 16);

        // kw2=3: single beat on column 6.
        clear_logs();
        add_word(rand_data(), 3, 16'h0bad, 1'b1);
        run(100, 100, -1, 100);
        check("t3_nbeats", beat_cols.size(), 1);
        if (beat_cols.size() == 1) check("t3_col", beat_cols[0], 6);

        // kw2=1 with random stalls.
        for (int i = 0; i < 6; i++) add_word(rand_data(), 1, 16'($urandom), 1'($urandom));
        run(50, 70, -1, 2000);

        // Reset after the third beat of a kw2=0 word, then a fresh word starts at column 0.
        clear_logs();
        add_word(rand_data(), 0, 16'h7777, 1'b1);
        run(100, 100, 3, 200);
        check("t5_beats_before_reset", beat_cols.size(), 3);
        clear_logs();
        add_word(rand_data(), 0, 16'h8888, 1'b1);
        run(100, 100, -1, 100);
        check("t5_nbeats", beat_cols.size(), 8);
        if (beat_cols.size() > 0) check("t5_first_col", beat_cols[0], 0);

        // Side-band pass-through with last=0.
        add_word(rand_data(), 0, 16'hA5A5, 1'b0);
        add_word(rand_data(), 2, 16'hA5A5, 1'b0);
        run(70, 100, -1, 500);

        // Random mix of kernel widths, stalls and gaps.
        for (int i = 0; i < 40; i++)
            add_word(rand_data(), int'($urandom_range(3)), 16'($urandom), 1'($urandom));
        run(60, 60, -1, 5000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
